seven_seg_scanner: RTL

- Parametrised, time-multiplexed seven-segment driver for N-digit common-anode displays.
- Next generation of the fixed 8-digit scanner; generalised in digit count and scan rate.
- New features: double-buffered tear-free updates with valid/ready load, per-digit blink, PWM brightness, leading-zero blanking, and a frame-start strobe.
- Sits between a memory-mapped display register block and the board's segment/anode pins.

---
 rtl/seven_seg_scanner.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a
// double-buffered display image, blink, PWM brightness and leading-zero blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_LOG2 = 11,
    parameter int BRIGHT_WIDTH  = 4,
    parameter int BLINK_WIDTH   = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     point,
    input  logic [NUM_DIGITS-1:0]     enable,
    input  logic [NUM_DIGITS-1:0]     blink,
    input  logic                      lz_blank,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [BRIGHT_WIDTH-1:0]   brightness,
    output logic                      frame_start,
    output logic [7:0]                segment,
    output logic [NUM_DIGITS-1:0]     digit
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [PRESCALE_LOG2-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BLINK_WIDTH-1:0]   blink_cnt_q, blink_cnt_d;

    logic [4*NUM_DIGITS-1:0]  act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]    act_point_q, act_point_d;
    logic [NUM_DIGITS-1:0]    act_enable_q, act_enable_d;
    logic [NUM_DIGITS-1:0]    act_blink_q, act_blink_d;
    logic                     act_lz_q, act_lz_d;

    logic [4*NUM_DIGITS-1:0]  pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]    pend_point_q, pend_point_d;
    logic [NUM_DIGITS-1:0]    pend_enable_q, pend_enable_d;
    logic [NUM_DIGITS-1:0]    pend_blink_q, pend_blink_d;
    logic                     pend_lz_q, pend_lz_d;
    logic                     pending_full_q, pending_full_d;

    logic [7:0]               segment_q, segment_d;
    logic [NUM_DIGITS-1:0]    digit_q, digit_d;
    logic                     frame_start_q, frame_start_d;

    logic                     frame_boundary;
    logic                     load_fire;
    logic [3:0]               cur_nib;
    logic                     cur_point, cur_en, cur_blink;
    logic                     upper_zero, lz_cur;
    logic [NUM_DIGITS-1:0]    digit_sel;
    logic [7:0]               glyph;
    logic [BRIGHT_WIDTH-1:0]  phase;
    logic                     dark;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    assign load_ready  = !pending_full_q && !reset;
    assign load_fire   = load_valid && !pending_full_q;
    assign frame_start = frame_start_q;
    assign segment     = segment_q;
    assign digit       = digit_q;

    // Counters and buffer transfer
    always_comb begin
        slot_cnt_d  = slot_cnt_q + PRESCALE_LOG2'(1);
        blink_cnt_d = blink_cnt_q + BLINK_WIDTH'(1);
        idx_d       = idx_q;
        if (&slot_cnt_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        frame_boundary = (&slot_cnt_q) && (idx_q == IDX_W'(NUM_DIGITS - 1));

        act_value_d    = act_value_q;
        act_point_d    = act_point_q;
        act_enable_d   = act_enable_q;
        act_blink_d    = act_blink_q;
        act_lz_d       = act_lz_q;
        pend_value_d   = pend_value_q;
        pend_point_d   = pend_point_q;
        pend_enable_d  = pend_enable_q;
        pend_blink_d   = pend_blink_q;
        pend_lz_d      = pend_lz_q;
        pending_full_d = pending_full_q;

        // Load and commit are mutually exclusive: load needs an empty pending buffer.
        if (frame_boundary && pending_full_q) begin
            act_value_d    = pend_value_q;
            act_point_d    = pend_point_q;
            act_enable_d   = pend_enable_q;
            act_blink_d    = pend_blink_q;
            act_lz_d       = pend_lz_q;
            pending_full_d = 1'b0;
        end else if (load_fire) begin
            pend_value_d   = value;
            pend_point_d   = point;
            pend_enable_d  = enable;
            pend_blink_d   = blink;
            pend_lz_d      = lz_blank;
            pending_full_d = 1'b1;
        end
    end

    // Glyph and anode selection for the digit currently being scanned
    always_comb begin
        cur_nib    = '0;
        cur_point  = 1'b0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        upper_zero = 1'b1;
        digit_sel  = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib      = act_value_q[4*k +: 4];
                cur_point    = act_point_q[k];
                cur_en       = act_enable_q[k];
                cur_blink    = act_blink_q[k];
                digit_sel[k] = 1'b0;
            end
            if ((IDX_W'(k) >= idx_q) && (act_value_q[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        lz_cur = act_lz_q && (idx_q != '0) && upper_zero;
        glyph  = {(lz_cur ? 7'h7F : hex_glyph(cur_nib)), ~cur_point};
        phase  = slot_cnt_q[PRESCALE_LOG2-1 -: BRIGHT_WIDTH];
        dark   = !cur_en
              || (cur_blink && blink_cnt_q[BLINK_WIDTH-1])
              || (phase > brightness)
              || (glyph == 8'hFF);

        segment_d     = dark ? 8'hFF : glyph;
        digit_d       = dark ? '1 : digit_sel;
        frame_start_d = (slot_cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q     <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            act_value_q    <= '0;
            act_point_q    <= '0;
            act_enable_q   <= '0;
            act_blink_q    <= '0;
            act_lz_q       <= 1'b0;
            pend_value_q   <= '0;
            pend_point_q   <= '0;
            pend_enable_q  <= '0;
            pend_blink_q   <= '0;
            pend_lz_q      <= 1'b0;
            pending_full_q <= 1'b0;
            segment_q      <= '1;
            digit_q        <= '1;
            frame_start_q  <= 1'b0;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            act_value_q    <= act_value_d;
            act_point_q    <= act_point_d;
            act_enable_q   <= act_enable_d;
            act_blink_q    <= act_blink_d;
            act_lz_q       <= act_lz_d;
            pend_value_q   <= pend_value_d;
            pend_point_q   <= pend_point_d;
            pend_enable_q  <= pend_enable_d;
            pend_blink_q   <= pend_blink_d;
            pend_lz_q      <= pend_lz_d;
            pending_full_q <= pending_full_d;
            segment_q      <= segment_d;
            digit_q        <= digit_d;
            frame_start_q  <= frame_start_d;
        end
    end

endmodule
